// File: rtl/sys_cmd_ctrl_pkg.sv
// rtl/sys_cmd_ctrl_pkg.sv - opcodes, operand addresses and FSM states for sys_cmd_ctrl
package sys_cmd_ctrl_pkg;

   localparam logic [7:0] CMD_WR     = 8'hAA;
   localparam logic [7:0] CMD_RD     = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP = 8'hCC;
   localparam logic [7:0] CMD_ALU    = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OPA,
      OPB,
      FUN,
      ALU_WAIT,
      TX_LO,
      TX_HI,
      RD_TX
   } state_e;

   // States that wait for the next frame byte from the host
   function automatic logic is_frame_state(state_e s);
      return s inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN};
   endfunction

endpackage

// File: rtl/sys_cmd_ctrl_timeout_cnt.sv
// rtl/sys_cmd_ctrl_timeout_cnt.sv - inter-byte timeout counter, built only with CMD_TIMEOUT_EN
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_cnt #(
   parameter int LIMIT = 1024
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !run_i) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(LIMIT));

endmodule
`endif

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART command sequencer driving register file and ALU
// Optional inter-byte frame timeout: CMD_TIMEOUT_EN.
module sys_cmd_ctrl
   import sys_cmd_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_FUN_WIDTH  = 4,
   parameter int ALU_OUT_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_valid,
   output logic                     rf_wr_en,
   output logic                     rf_rd_en,
   output logic [ADDR_WIDTH-1:0]    rf_addr,
   output logic [DATA_WIDTH-1:0]    rf_wr_data,
   input  logic [DATA_WIDTH-1:0]    rf_rd_data,
   input  logic                     rf_rd_valid,
   input  logic                     rf_wr_done,
   output logic                     alu_en,
   output logic [ALU_FUN_WIDTH-1:0] alu_fun,
   input  logic [ALU_OUT_WIDTH-1:0] alu_out,
   input  logic                     alu_out_valid,
   output logic                     clk_gate_en,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   input  logic                     tx_busy,
   output logic                     cmd_err
);

   state_e                   state_q, state_d;
   logic                     rf_wr_en_q, rf_wr_en_d;
   logic                     rf_rd_en_q, rf_rd_en_d;
   logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
   logic                     alu_en_q, alu_en_d;
   logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
   logic                     clk_gate_en_q, clk_gate_en_d;
   logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
   logic                     tx_valid_q, tx_valid_d;
   logic                     cmd_err_q, cmd_err_d;
   logic [DATA_WIDTH-1:0]    rd_q, rd_d;
   logic [ALU_OUT_WIDTH-1:0] res_q, res_d;
   logic                     unused_in;

`ifdef CMD_TIMEOUT_EN
   logic to_expired;

   cmd_timeout_cnt #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK      (CLK),
      .RST      (RST),
      .clr_i    (rx_valid),
      .run_i    (is_frame_state(state_q)),
      .expired_o(to_expired)
   );

   assign unused_in = rf_wr_done;
`else
   assign unused_in = rf_wr_done ^ (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d      = state_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      alu_en_d     = 1'b0;
      alu_fun_d    = alu_fun_q;
      tx_valid_d   = 1'b0;
      tx_data_d    = tx_data_q;
      cmd_err_d    = 1'b0;
      rd_d         = rd_q;
      res_d        = res_q;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == DATA_WIDTH'(CMD_WR))          state_d = WR_ADDR;
               else if (rx_data == DATA_WIDTH'(CMD_RD))     state_d = RD_ADDR;
               else if (rx_data == DATA_WIDTH'(CMD_ALU_OP)) state_d = OPA;
               else if (rx_data == DATA_WIDTH'(CMD_ALU))    state_d = FUN;
               else                                         cmd_err_d = 1'b1;
            end
         end
         WR_ADDR: begin
            if (rx_valid) begin
               rf_addr_d = rx_data[ADDR_WIDTH-1:0];
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_wr_data_d = rx_data;
               state_d      = IDLE;
            end
         end
         RD_ADDR: begin
            if (rx_valid) begin
               rf_rd_en_d = 1'b1;
               rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rf_rd_valid) begin
               rd_d    = rf_rd_data;
               state_d = RD_TX;
            end
         end
         RD_TX: begin
            if (!tx_busy) begin
               tx_valid_d = 1'b1;
               tx_data_d  = rd_q;
               state_d    = IDLE;
            end
         end
         OPA: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
               rf_wr_data_d = rx_data;
               state_d      = OPB;
            end
         end
         OPB: begin
            if (rx_valid) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
               rf_wr_data_d = rx_data;
               state_d      = FUN;
            end
         end
         FUN: begin
            if (rx_valid) begin
               alu_fun_d = rx_data[ALU_FUN_WIDTH-1:0];
               alu_en_d  = 1'b1;
               state_d   = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (alu_out_valid) begin
               res_d   = alu_out;
               state_d = TX_LO;
            end
         end
         TX_LO: begin
            if (!tx_busy) begin
               tx_valid_d = 1'b1;
               tx_data_d  = res_q[DATA_WIDTH-1:0];
               state_d    = TX_HI;
            end
         end
         TX_HI: begin
            // The UART sees the low byte one cycle late; skip that cycle so pulses never merge
            if (!tx_busy && !tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef CMD_TIMEOUT_EN
      if (to_expired && !rx_valid) begin
         state_d   = IDLE;
         cmd_err_d = 1'b1;
      end
`endif

      clk_gate_en_d = state_d inside {FUN, ALU_WAIT, TX_LO, TX_HI};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= IDLE;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         cmd_err_q     <= 1'b0;
         rd_q          <= '0;
         res_q         <= '0;
      end else begin
         state_q       <= state_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_data_q  <= rf_wr_data_d;
         alu_en_q      <= alu_en_d;
         alu_fun_q     <= alu_fun_d;
         clk_gate_en_q <= clk_gate_en_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         cmd_err_q     <= cmd_err_d;
         rd_q          <= rd_d;
         res_q         <= res_d;
      end
   end

   assign rf_wr_en    = rf_wr_en_q;
   assign rf_rd_en    = rf_rd_en_q;
   assign rf_addr     = rf_addr_q;
   assign rf_wr_data  = rf_wr_data_q;
   assign alu_en      = alu_en_q;
   assign alu_fun     = alu_fun_q;
   assign clk_gate_en = clk_gate_en_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb/tb_sys_cmd_ctrl.sv - self-checking bench for sys_cmd_ctrl
module tb_sys_cmd_ctrl;

   localparam int TIMEOUT = 1024;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid, cmd_err;
   logic [3:0]  rf_addr, alu_fun;
   logic [7:0]  rf_wr_data, tx_data;
   logic [7:0]  rf_rd_data = 8'h00;
   logic        rf_rd_valid = 1'b0;
   logic        rf_wr_done = 1'b0;
   logic [15:0] alu_out = 16'h0000;
   logic        alu_out_valid = 1'b0;
   logic        busy_force = 1'b0;
   int          busy_cnt = 0;
   logic        tx_busy;

   assign tx_busy = busy_force || (busy_cnt != 0);

   always #5 CLK = ~CLK;

   sys_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .ALU_OUT_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
      .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .rf_wr_done(rf_wr_done),
      .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
      .clk_gate_en(clk_gate_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
      .cmd_err(cmd_err)
   );

   int n_pass = 0;
   int n_total = 0;

   logic [11:0] got_wr[$], exp_wr[$];
   logic [3:0]  got_rd[$], exp_rd[$];
   logic [7:0]  got_tx[$], exp_tx[$];
   logic [3:0]  got_fun[$], exp_fun[$];
   int          got_err = 0, exp_err = 0, viol = 0;
   logic [7:0]  rf_mem[16];
   logic [7:0]  ref_mem[16];
   logic        gate_at_alu = 1'b0;
   logic        alu_ovr_en = 1'b0;
   logic [15:0] alu_ovr_val = 16'h0000;
   logic        busy_seen = 1'b0;
   logic [4:0]  prev_pulses = '0;
   int          rd_cnt = 0, alu_cnt = 0;
   logic [3:0]  rd_addr_l = '0;
   logic [15:0] alu_pend = '0;

   // Reference ALU behaviour shared by the environment model and the expectation builder
   function automatic logic [15:0] alu_ref(logic [3:0] f, logic [7:0] a, logic [7:0] b);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return {a, b};
         default: return {8'h00, a ^ b};
      endcase
   endfunction

   always @(posedge CLK) busy_seen <= tx_busy;

   // Register file, ALU and UART models plus pulse-protocol monitor
   always @(negedge CLK) begin
      logic [4:0] pulses;
      rf_rd_valid   = 1'b0;
      alu_out_valid = 1'b0;
      rf_wr_done    = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            rf_rd_valid = 1'b1;
            rf_rd_data  = rf_mem[rd_addr_l];
         end
      end
      if (alu_cnt > 0) begin
         alu_cnt--;
         if (alu_cnt == 0) begin
            alu_out_valid = 1'b1;
            alu_out       = alu_pend;
         end
      end
      pulses = {rf_wr_en, rf_rd_en, alu_en, tx_valid, cmd_err};
      if ((pulses & prev_pulses) != 0) viol++;
      if (rf_wr_en && rf_rd_en) viol++;
      if (tx_valid && busy_seen) viol++;
      prev_pulses = pulses;
      if (rf_wr_en) begin
         got_wr.push_back({rf_addr, rf_wr_data});
         rf_mem[rf_addr] = rf_wr_data;
         rf_wr_done = 1'b1;
      end
      if (rf_rd_en) begin
         got_rd.push_back(rf_addr);
         rd_cnt    = 2;
         rd_addr_l = rf_addr;
      end
      if (alu_en) begin
         got_fun.push_back(alu_fun);
         gate_at_alu = clk_gate_en;
         alu_cnt     = 3;
         alu_pend    = alu_ovr_en ? alu_ovr_val : alu_ref(alu_fun, rf_mem[0], rf_mem[1]);
      end
      if (tx_valid) begin
         got_tx.push_back(tx_data);
         busy_cnt = $urandom_range(0, 4);
      end
      if (cmd_err) got_err++;
   end

   task automatic check(string name, longint act, longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_write(logic [3:0] a, logic [7:0] d);
      exp_wr.push_back({a, d});
      ref_mem[a] = d;
   endtask

   task automatic exp_read(logic [3:0] a);
      exp_rd.push_back(a);
      exp_tx.push_back(ref_mem[a]);
   endtask

   task automatic exp_alu(logic [3:0] f, logic [15:0] r);
      exp_fun.push_back(f);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
   endtask

   task automatic send_byte(logic [7:0] b);
      @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic send_gap(logic [7:0] b);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_byte(b);
   endtask

   task automatic settle();
      repeat (40) @(negedge CLK);
   endtask

   task automatic compare_all(string tag);
      check({tag, " wr_count"}, got_wr.size(), exp_wr.size());
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         check($sformatf("%s wr[%0d]", tag, i), got_wr[i], exp_wr[i]);
      check({tag, " rd_count"}, got_rd.size(), exp_rd.size());
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         check($sformatf("%s rd[%0d]", tag, i), got_rd[i], exp_rd[i]);
      check({tag, " tx_count"}, got_tx.size(), exp_tx.size());
      for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
         check($sformatf("%s tx[%0d]", tag, i), got_tx[i], exp_tx[i]);
      check({tag, " alu_count"}, got_fun.size(), exp_fun.size());
      for (int i = 0; i < got_fun.size() && i < exp_fun.size(); i++)
         check($sformatf("%s fun[%0d]", tag, i), got_fun[i], exp_fun[i]);
      check({tag, " cmd_err"}, got_err, exp_err);
      check({tag, " protocol"}, viol, 0);
      check({tag, " gate_idle"}, clk_gate_en, 0);
      got_wr.delete(); exp_wr.delete(); got_rd.delete(); exp_rd.delete();
      got_tx.delete(); exp_tx.delete(); got_fun.delete(); exp_fun.delete();
      got_err = 0; exp_err = 0; viol = 0;
   endtask

   typedef struct {
      logic [31:0] bytes;
      int          n;
      bit          ovr;
      logic [15:0] ovr_val;
      int          nwr;
      logic [11:0] wr0, wr1;
      int          nrd;
      logic [3:0]  rd0;
      int          ntx;
      logic [7:0]  tx0, tx1;
      int          nfun;
      logic [3:0]  fun0;
      int          nerr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fb[$];
      logic [7:0] a, d, x, y, f;
      for (int i = 0; i < 16; i++) begin rf_mem[i] = 8'h00; ref_mem[i] = 8'h00; end

      //         bytes         n  ovr  val      nwr wr0     wr1     nrd rd0   ntx tx0    tx1    nfun fun0  nerr
      vecs[0] = '{32'hAA053C00, 3, 0, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 0};
      vecs[1] = '{32'hBB050000, 2, 0, 16'h0000, 0, 12'h000, 12'h000, 1, 4'h5, 1, 8'h3C, 8'h00, 0, 4'h0, 0};
      vecs[2] = '{32'hCC0A0300, 4, 0, 16'h0000, 2, 12'h00A, 12'h103, 0, 4'h0, 2, 8'h0D, 8'h00, 1, 4'h0, 0};
      vecs[3] = '{32'hDD020000, 2, 1, 16'h1234, 0, 12'h000, 12'h000, 0, 4'h0, 2, 8'h34, 8'h12, 1, 4'h2, 0};
      vecs[4] = '{32'h57000000, 1, 0, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 1};
      vecs[5] = '{32'hAAF71100, 3, 0, 16'h0000, 1, 12'h711, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 0};
      vecs[6] = '{32'hBBF70000, 2, 0, 16'h0000, 0, 12'h000, 12'h000, 1, 4'h7, 1, 8'h11, 8'h00, 0, 4'h0, 0};
      vecs[7] = '{32'hAB000000, 1, 0, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 1};

      repeat (2) @(negedge CLK);
      check("reset_outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                              clk_gate_en, tx_data, tx_valid, cmd_err}, 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].nwr > 0) exp_write(vecs[v].wr0[11:8], vecs[v].wr0[7:0]);
         if (vecs[v].nwr > 1) exp_write(vecs[v].wr1[11:8], vecs[v].wr1[7:0]);
         if (vecs[v].nrd > 0) exp_rd.push_back(vecs[v].rd0);
         if (vecs[v].ntx > 0) exp_tx.push_back(vecs[v].tx0);
         if (vecs[v].ntx > 1) exp_tx.push_back(vecs[v].tx1);
         if (vecs[v].nfun > 0) exp_fun.push_back(vecs[v].fun0);
         exp_err     = vecs[v].nerr;
         alu_ovr_en  = vecs[v].ovr;
         alu_ovr_val = vecs[v].ovr_val;
         gate_at_alu = 1'b0;
         for (int i = 0; i < vecs[v].n; i++) send_gap(vecs[v].bytes[31 - 8*i -: 8]);
         settle();
         if (vecs[v].nfun > 0) check($sformatf("vec%0d gate_at_alu", v), gate_at_alu, 1);
         compare_all($sformatf("vec%0d", v));
      end
      alu_ovr_en = 1'b0;

      // TX back-pressure with a stray byte arriving while the result is held
      busy_force = 1'b1;
      exp_alu(4'h5, alu_ref(4'h5, ref_mem[0], ref_mem[1]));
      send_byte(8'hDD);
      send_byte(8'h05);
      repeat (10) @(negedge CLK);
      send_byte(8'h57);
      repeat (40) @(negedge CLK);
      check("busy tx_held", got_tx.size(), 0);
      busy_force = 1'b0;
      settle();
      compare_all("busy");

      // Reset in the middle of a write frame
      send_byte(8'hAA);
      send_byte(8'h05);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("reset_mid outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                                  clk_gate_en, tx_data, tx_valid, cmd_err}, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      exp_write(4'h6, 8'h22);
      send_byte(8'hAA);
      send_byte(8'h06);
      send_byte(8'h22);
      settle();
      compare_all("reset_mid");

      // A long pause inside a frame that stays under the timeout limit
      exp_write(4'h6, 8'h33);
      send_byte(8'hAA);
      repeat (200) @(negedge CLK);
      send_byte(8'h06);
      send_byte(8'h33);
      settle();
      compare_all("slow_frame");

`ifdef CMD_TIMEOUT_EN
      exp_err = 1;
      send_byte(8'hAA);
      repeat (TIMEOUT + 20) @(negedge CLK);
      compare_all("timeout");
      exp_read(4'h6);
      send_byte(8'hBB);
      send_byte(8'h06);
      settle();
      compare_all("after_timeout");
`endif

      for (int t = 0; t < 40; t++) begin
         fb.delete();
         a = 8'($urandom); d = 8'($urandom); x = 8'($urandom); y = 8'($urandom); f = 8'($urandom);
         case ($urandom_range(0, 4))
            0: begin fb = '{8'hAA, a, d}; exp_write(a[3:0], d); end
            1: begin fb = '{8'hBB, a}; exp_read(a[3:0]); end
            2: begin
               fb = '{8'hCC, x, y, f};
               exp_write(4'h0, x);
               exp_write(4'h1, y);
               exp_alu(f[3:0], alu_ref(f[3:0], x, y));
            end
            3: begin fb = '{8'hDD, f}; exp_alu(f[3:0], alu_ref(f[3:0], ref_mem[0], ref_mem[1])); end
            default: begin
               while (a inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) a = 8'($urandom);
               fb = '{a};
               exp_err = 1;
            end
         endcase
         foreach (fb[i]) send_gap(fb[i]);
         settle();
         compare_all($sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Command sequencer between the UART RX/TX byte streams and the register file / ALU. It parses command frames from received bytes and issues single-cycle write and read strobes to the register file. It also loads ALU operands into REG0/REG1 through the register file, starts the ALU, and returns read data or the 16-bit ALU result to UART TX.

Parameters:
DATA_WIDTH, 8, byte width of the RX/TX and register-file data paths
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function-code width
ALU_OUT_WIDTH, 16, ALU result width; always 2*DATA_WIDTH
TIMEOUT_CYCLES, 1024, inter-byte timeout limit; used only with CMD_TIMEOUT_EN

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
rx_data  in  DATA_WIDTH  received byte
rx_valid  in  1  one-cycle pulse, rx_data valid
rf_wr_en  out  1  register-file write strobe
rf_rd_en  out  1  register-file read strobe
rf_addr  out  ADDR_WIDTH  register-file address
rf_wr_data  out  DATA_WIDTH  register-file write data
rf_rd_data  in  DATA_WIDTH  register-file read data
rf_rd_valid  in  1  read data valid
rf_wr_done  in  1  write acknowledged (informational; not waited on)
alu_en  out  1  one-cycle ALU start pulse
alu_fun  out  ALU_FUN_WIDTH  ALU function code, held stable until IDLE
alu_out  in  ALU_OUT_WIDTH  ALU result
alu_out_valid  in  1  ALU result valid
clk_gate_en  out  1  ALU clock-gate enable
tx_data  out  DATA_WIDTH  byte to transmit
tx_valid  out  1  one-cycle pulse, tx_data valid
tx_busy  in  1  TX busy; no tx_valid while high
cmd_err  out  1  one-cycle pulse on an unknown command byte

Behaviour:
- Reset: every output is 0; FSM is in IDLE.
- Reset is honoured mid-frame: it aborts any frame in progress, with no further strobes.
- All outputs are registered.
- rf_wr_en, rf_rd_en, alu_en, tx_valid and cmd_err are single-cycle pulses.
- rf_wr_en and rf_rd_en are never high together.
- Commands, recognised as the first byte in IDLE:
  - 0xAA: write frame (addr, data)
  - 0xBB: read frame (addr)
  - 0xCC: ALU with operands (opA, opB, fun)
  - 0xDD: ALU without operands (fun)
- Any other first byte: pulse cmd_err, stay in IDLE.
- Address handling: rf_addr = rx_data[ADDR_WIDTH-1:0]; upper bits are ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI, RD_TX.
- Write frame (0xAA):
  - WR_ADDR on rx_valid: latch the address.
  - WR_DATA on rx_valid: pulse rf_wr_en with rf_wr_data = rx_data, go to IDLE.
  - Write latency: strobe in the cycle after the data byte's rx_valid.
- Read frame (0xBB):
  - RD_ADDR on rx_valid: pulse rf_rd_en, go to RD_WAIT.
  - RD_WAIT on rf_rd_valid: capture rf_rd_data, go to RD_TX.
  - RD_TX: when tx_busy = 0, pulse tx_valid with the captured byte, go to IDLE.
- ALU with operands (0xCC):
  - OPA on rx_valid: write rx_data to address 0.
  - OPB on rx_valid: write rx_data to address 1.
  - Then continue as FUN.
- FUN (entered directly from 0xDD):
  - clk_gate_en = 1 from entry into FUN until return to IDLE.
  - On rx_valid: alu_fun = rx_data[ALU_FUN_WIDTH-1:0], pulse alu_en the next cycle, go to ALU_WAIT.
- ALU_WAIT on alu_out_valid: capture alu_out, go to TX_LO.
- TX_LO / TX_HI: wait for tx_busy = 0, send the low byte then the high byte, then go to IDLE.
- rx_valid outside a byte-consuming state is ignored:
  - byte-consuming states are IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN;
  - in RD_WAIT, ALU_WAIT and the TX states the byte is dropped.
- A tx_valid pulse is issued only in a cycle where tx_busy = 0; tx_busy rising later does not cancel it.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- With the macro defined:
  - a counter clears on every rx_valid and counts while in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB or FUN;
  - when it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with no strobes, pulses cmd_err and drops clk_gate_en;
  - wait states (RD_WAIT, ALU_WAIT, TX) are never timed out.
- Without the macro: no counter; partial frames wait indefinitely.

Decomposition:
- Shared package: command opcode constants (0xAA/0xBB/0xCC/0xDD), FSM state enum, fixed operand addresses (0, 1).
- No sub-module by default.
- Under CMD_TIMEOUT_EN, the counter is the sub-module cmd_timeout_cnt (inputs clr, run; output expired).

Test Plan:
- Write then read back:
  - AA,05,3C → one rf_wr_en with addr 5, data 3C;
  - then BB,05 → one rf_rd_en with addr 5; model returns 3C → one tx_valid with tx_data = 3C.
- ALU with operands:
  - CC,0A,03,00 → writes 0A to addr 0 and 03 to addr 1, alu_fun = 0, one alu_en;
  - alu_out = 000D → tx bytes 0D then 00;
  - clk_gate_en high from FUN entry to IDLE.
- ALU without operands: DD,02 with alu_out = 1234 → tx 34 then 12, no rf strobes.
- Unknown command and address truncation:
  - 57 → one cmd_err pulse, FSM still IDLE;
  - then AA,F7,11 → write to addr 7.
- Back-pressure and reset:
  - tx_busy held high 50 cycles during TX_LO → no tx_valid until release;
  - RST low mid-frame (after AA,05) → all outputs 0;
  - then AA,06,22 → write to addr 6.
- CMD_TIMEOUT_EN:
  - AA then silence for TIMEOUT_CYCLES → cmd_err, back in IDLE;
  - a following BB,06 read works normally.
